// File: rtl/measuring_vibrations_if.sv
// Board-facing signal bundle for the vibration logger: accelerometer SPI link,
// accelerometer interrupt lines and the UART pair.
interface measuring_vibrations_if;
  logic MOSI;
  logic MISO;
  logic SCL;
  logic CS;
  logic INT1;
  logic INT2;
  logic UART_RX;
  logic UART_TX;

  modport master (output MOSI, SCL, CS, UART_TX, input MISO, INT1, INT2, UART_RX);
  modport slave  (input MOSI, SCL, CS, UART_TX, output MISO, INT1, INT2, UART_RX);
endinterface

// File: rtl/measuring_vibrations.sv
// Accelerometer logger: configures the sensor over SPI mode 3, reads XYZ at the
// sample rate, shows X0 on LEDR and streams an A5-prefixed frame out of the UART.
module measuring_vibrations #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int SPI_HALF   = 4,
  parameter int BAUD_DIV   = 104,
  parameter int SAMPLE_DIV = 120_000
) (
  input  logic                   sys_clock,
  input  logic                   reset,
  measuring_vibrations_if.master bus,
  output logic [7:0]             LEDR
);

  localparam int HALF_W   = (SPI_HALF   > 1) ? $clog2(SPI_HALF)   : 1;
  localparam int BAUD_W   = (BAUD_DIV   > 1) ? $clog2(BAUD_DIV)   : 1;
  localparam int SAMPLE_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [HALF_W-1:0]   HALF_LAST   = HALF_W'(SPI_HALF - 1);
  localparam logic [BAUD_W-1:0]   BAUD_LAST   = BAUD_W'(BAUD_DIV - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);
  // Half-periods per transaction: 2 guard, 1 lead, 16 per byte minus 1, 1 tail.
  localparam logic [7:0] CFG_STEPS  = 8'd35;
  localparam logic [7:0] READ_STEPS = 8'd115;

  typedef enum logic [2:0] {INIT_WAIT, CFG_WRITE, IDLE, READ, UART_SEND} state_t;

  state_t              state, next_state;
  logic [3:0]          init_cnt;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic                sample_tick;
  logic [HALF_W-1:0]   half_cnt;
  logic                half_tick;
  logic [7:0]          step, next_step, spi_steps, data_pos;
  logic                in_spi, spi_start, spi_done;
  logic [3:0]          spi_byte;
  logic [2:0]          spi_bit;
  logic [7:0]          tx_byte;
  logic [6:0]          rx_shift;
  logic [7:0]          capture [6];
  logic [7:0]          frame [7];
  logic                cs_q, scl_q, mosi_q;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [3:0]          uart_bit;
  logic [2:0]          uart_byte;
  logic                uart_tx_q, uart_done;
  logic                unused_inputs;

  assign sample_tick = (sample_cnt == SAMPLE_LAST);
  assign half_tick   = (half_cnt == HALF_LAST);
  assign in_spi      = (state == CFG_WRITE) || (state == READ);
  assign spi_steps   = (state == READ) ? READ_STEPS : CFG_STEPS;
  assign next_step   = step + 8'd1;
  assign data_pos    = next_step - 8'd3;
  assign spi_byte    = data_pos[7:4];
  assign spi_bit     = data_pos[3:1];
  assign spi_done    = in_spi && half_tick && (next_step == spi_steps);
  assign uart_done   = (state == UART_SEND) && (baud_cnt == BAUD_LAST) &&
                       (uart_bit == 4'd9) && (uart_byte == 3'd6);

  assign bus.CS      = cs_q;
  assign bus.SCL     = scl_q;
  assign bus.MOSI    = mosi_q;
  assign bus.UART_TX = uart_tx_q;
  assign unused_inputs = ^{bus.INT1, bus.INT2, bus.UART_RX, CLK_HZ[0]};

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (sample_tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + SAMPLE_W'(1);
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state == INIT_WAIT) begin
      init_cnt <= init_cnt + 4'd1;
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state <= INIT_WAIT;
    end else begin
      state <= next_state;
    end
  end

  // Ticks are only honoured in IDLE, so ones landing in READ/UART_SEND are lost.
  always_comb begin
    next_state = state;
    spi_start  = 1'b0;
    case (state)
      INIT_WAIT: if (init_cnt == 4'd15) begin
        next_state = CFG_WRITE;
        spi_start  = 1'b1;
      end
      CFG_WRITE: if (spi_done) next_state = IDLE;
      IDLE:      if (sample_tick) begin
        next_state = READ;
        spi_start  = 1'b1;
      end
      READ:      if (spi_done) next_state = UART_SEND;
      UART_SEND: if (uart_done) next_state = IDLE;
      default:   next_state = INIT_WAIT;
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state == CFG_WRITE) begin
      tx_byte = (spi_byte == 4'd0) ? 8'h2D : 8'h08;
    end else if (spi_byte == 4'd0) begin
      tx_byte = 8'hF2;
    end
  end

  // Even data steps are SCL falls (drive MOSI), odd ones are rises (sample MISO).
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      step     <= '0;
      half_cnt <= '0;
      cs_q     <= 1'b1;
      scl_q    <= 1'b1;
      mosi_q   <= 1'b0;
      rx_shift <= '0;
      for (int i = 0; i < 6; i++) capture[i] <= '0;
    end else if (spi_start) begin
      step     <= '0;
      half_cnt <= '0;
    end else if (in_spi) begin
      if (!half_tick) begin
        half_cnt <= half_cnt + HALF_W'(1);
      end else begin
        half_cnt <= '0;
        step     <= next_step;
        if (next_step == 8'd2) begin
          cs_q <= 1'b0;
        end else if (next_step == spi_steps) begin
          cs_q   <= 1'b1;
          mosi_q <= 1'b0;
        end else if (next_step >= 8'd3) begin
          if (!data_pos[0]) begin
            scl_q  <= 1'b0;
            mosi_q <= tx_byte[~spi_bit];
          end else begin
            scl_q    <= 1'b1;
            rx_shift <= {rx_shift[5:0], bus.MISO};
            if ((state == READ) && (spi_bit == 3'd7) && (spi_byte != 4'd0)) begin
              capture[3'(spi_byte - 4'd1)] <= {rx_shift, bus.MISO};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      LEDR <= '0;
      for (int i = 0; i < 7; i++) frame[i] <= '0;
    end else if (spi_done && (state == READ)) begin
      LEDR     <= capture[0];
      frame[0] <= 8'hA5;
      for (int i = 1; i < 7; i++) frame[i] <= capture[i-1];
    end
  end

  // uart_bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      uart_tx_q <= 1'b1;
      baud_cnt  <= '0;
      uart_bit  <= '0;
      uart_byte <= '0;
    end else if (spi_done && (state == READ)) begin
      uart_tx_q <= 1'b0;
      baud_cnt  <= '0;
      uart_bit  <= '0;
      uart_byte <= '0;
    end else if (state == UART_SEND) begin
      if (baud_cnt != BAUD_LAST) begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end else begin
        baud_cnt <= '0;
        if (uart_bit == 4'd9) begin
          uart_bit <= '0;
          if (uart_byte == 3'd6) begin
            uart_tx_q <= 1'b1;
          end else begin
            uart_byte <= uart_byte + 3'd1;
            uart_tx_q <= 1'b0;
          end
        end else begin
          uart_bit  <= uart_bit + 4'd1;
          uart_tx_q <= (uart_bit == 4'd8) ? 1'b1 : frame[uart_byte][uart_bit[2:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_measuring_vibrations.sv
// Bench for measuring_vibrations: SPI slave model, UART decoder with an
// expected-byte scoreboard, table-driven READ vectors and reset corner cases.
module tb_measuring_vibrations;
  localparam int SPI_HALF   = 4;
  localparam int BAUD_DIV   = 104;
  localparam int SAMPLE_DIV = 3000;
  localparam int CFG_LOW    = 33 * SPI_HALF;
  localparam int READ_LOW   = 113 * SPI_HALF;

  typedef struct {
    int          rises;
    int          low_len;
    int          lead;
    int          tail;
    logic [55:0] mosi;
  } txn_t;

  typedef struct {
    logic [47:0] resp;
    logic [7:0]  exp_ledr;
  } vec_t;

  logic       sys_clock = 1'b0;
  logic       reset;
  logic [7:0] LEDR;
  measuring_vibrations_if bus();

  measuring_vibrations #(
    .CLK_HZ(12_000_000), .SPI_HALF(SPI_HALF), .BAUD_DIV(BAUD_DIV), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .sys_clock(sys_clock), .reset(reset), .bus(bus), .LEDR(LEDR)
  );

  always #5ns sys_clock = ~sys_clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          prev_cs = 1'b1;
  bit          prev_scl = 1'b1;
  int          n_rise = 0;
  int          n_fall = 0;
  int          fall_cyc, first_fall_cyc, last_rise_cyc;
  logic [55:0] mosi_acc = '0;
  logic [47:0] slave_resp = '0;
  txn_t        txn_q[$];
  logic [7:0]  exp_uart_q[$];
  bit          frame_active = 1'b0;
  int          frame_bytes = 0;
  int          uart_starts = 0;
  bit          toggle_en = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    slave_resp = v.resp;
    exp_uart_q.push_back(8'hA5);
    for (int j = 0; j < 6; j++) exp_uart_q.push_back(v.resp[47 - 8*j -: 8]);
    $display("[TB] vector resp=%h", v.resp);
  endtask

  task automatic wait_txn(input int max_cycles, output txn_t t, output bit ok);
    int n = 0;
    while (txn_q.size() == 0 && n < max_cycles) begin
      @(negedge sys_clock);
      n++;
    end
    ok = (txn_q.size() != 0);
    if (ok) t = txn_q.pop_front();
    check_output("spi_txn_arrived", ok, 1);
  endtask

  // SPI slave and bus monitor, sampled on the falling system clock edge.
  always @(negedge sys_clock) begin
    logic [7:0] slv;
    int j;
    cyc++;
    if (prev_cs && bus.CS === 1'b0) begin
      check_output("read_overlaps_uart", frame_active, 0);
      n_rise = 0;
      n_fall = 0;
      fall_cyc = cyc;
      mosi_acc = '0;
    end
    if (bus.CS === 1'b0 && prev_scl && bus.SCL === 1'b0) begin
      if (n_fall == 0) first_fall_cyc = cyc;
      j = n_fall / 8;
      slv = (j >= 1 && j <= 6) ? slave_resp[47 - 8*(j-1) -: 8] : 8'h00;
      bus.MISO = slv[7 - (n_fall % 8)];
      n_fall++;
    end
    if (bus.CS === 1'b0 && !prev_scl && bus.SCL === 1'b1) begin
      last_rise_cyc = cyc;
      mosi_acc = {mosi_acc[54:0], bus.MOSI};
      n_rise++;
    end
    if (!prev_cs && bus.CS === 1'b1) begin
      if (reset === 1'b0)
        txn_q.push_back('{n_rise, cyc - fall_cyc, first_fall_cyc - fall_cyc, cyc - last_rise_cyc, mosi_acc});
      n_fall = 0;
    end
    prev_cs = (bus.CS !== 1'b0);
    prev_scl = (bus.SCL !== 1'b0);
  end

  initial begin : uart_monitor
    logic [7:0] got, exp;
    int depth;
    forever begin
      @(negedge sys_clock);
      if (reset === 1'b0 && bus.UART_TX === 1'b0) begin
        uart_starts++;
        frame_active = 1'b1;
        repeat (BAUD_DIV/2 - 1) @(negedge sys_clock);
        check_output("uart_start_bit", bus.UART_TX, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge sys_clock);
          got[i] = bus.UART_TX;
        end
        repeat (BAUD_DIV) @(negedge sys_clock);
        check_output("uart_stop_bit", bus.UART_TX, 1);
        depth = exp_uart_q.size();
        check_output("uart_byte_expected", depth != 0, 1);
        if (depth != 0) begin
          exp = exp_uart_q.pop_front();
          check_output("uart_byte", got, exp);
        end
        frame_bytes++;
        if (frame_bytes == 7) begin
          frame_bytes = 0;
          frame_active = 1'b0;
        end
      end
    end
  end

  // Ignored inputs get random noise while enabled.
  initial begin : noise
    forever begin
      @(negedge sys_clock);
      if (toggle_en) {bus.INT1, bus.INT2, bus.UART_RX} = 3'($urandom);
      else {bus.INT1, bus.INT2, bus.UART_RX} = 3'b001;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs[4];
    txn_t t;
    bit   ok;
    int   bad, n, starts_before;

    vecs[0] = '{48'h11_22_33_44_55_66, 8'h11};
    vecs[1] = '{48'h00_FF_80_01_7E_C3, 8'h00};
    vecs[2] = '{48'hFF_00_AA_55_0F_F0, 8'hFF};
    vecs[3] = '{48'h5A_A5_3C_C3_96_69, 8'h5A};

    reset = 1'b1;
    #150ns;
    check_output("reset_cs", bus.CS, 1);
    check_output("reset_scl", bus.SCL, 1);
    check_output("reset_mosi", bus.MOSI, 0);
    check_output("reset_uart_tx", bus.UART_TX, 1);
    check_output("reset_ledr", LEDR, 8'h00);
    #150ns;
    reset = 1'b0;

    bad = 0;
    repeat (16) begin
      @(negedge sys_clock);
      if (bus.CS !== 1'b1 || bus.SCL !== 1'b1 || bus.UART_TX !== 1'b1 || LEDR !== 8'h00) bad++;
    end
    check_output("init_wait_idle_cycles_bad", bad, 0);

    wait_txn(2000, t, ok);
    if (ok) begin
      check_output("cfg_rises", t.rises, 16);
      check_output("cfg_mosi", t.mosi[15:0], 16'h2D08);
      check_output("cfg_cs_low_len", t.low_len, CFG_LOW);
      check_output("cfg_lead", t.lead, SPI_HALF);
      check_output("cfg_tail", t.tail, SPI_HALF);
    end

    for (int i = 0; i < 4; i++) begin
      toggle_en = (i >= 1);
      apply_stimulus(vecs[i]);
      wait_txn(4 * SAMPLE_DIV, t, ok);
      if (ok) begin
        check_output("read_rises", t.rises, 56);
        check_output("read_mosi", t.mosi, 56'hF2_0000_0000_0000);
        check_output("read_cs_low_len", t.low_len, READ_LOW);
        check_output("read_lead", t.lead, SPI_HALF);
        check_output("read_tail", t.tail, SPI_HALF);
        check_output("read_ledr", LEDR, vecs[i].exp_ledr);
      end
    end

    n = 0;
    while ((exp_uart_q.size() != 0 || frame_active) && n < 20000) begin
      @(negedge sys_clock);
      n++;
    end
    check_output("uart_drain_left", exp_uart_q.size(), 0);
    check_output("uart_frame_incomplete", frame_active, 0);

    // Abort a READ in its fourth byte.
    n = 0;
    while (!(bus.CS === 1'b0 && n_fall >= 28) && n < 4 * SAMPLE_DIV) begin
      @(negedge sys_clock);
      n++;
    end
    check_output("abort_reached_byte3", (bus.CS === 1'b0 && n_fall >= 28), 1);
    starts_before = uart_starts;
    #3ns;
    reset = 1'b1;
    #1ns;
    check_output("abort_cs", bus.CS, 1);
    check_output("abort_scl", bus.SCL, 1);
    check_output("abort_ledr", LEDR, 8'h00);
    check_output("abort_uart_tx", bus.UART_TX, 1);
    repeat (5) @(negedge sys_clock);
    reset = 1'b0;

    wait_txn(2000, t, ok);
    if (ok) begin
      check_output("recfg_rises", t.rises, 16);
      check_output("recfg_mosi", t.mosi[15:0], 16'h2D08);
    end
    repeat (200) @(negedge sys_clock);
    check_output("abort_uart_starts", uart_starts - starts_before, 0);
    check_output("final_queue_left", exp_uart_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/measuring_vibrations.md
MEASURING_VIBRATIONS -- requirements
Module: measuring_vibrations

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter SPI_HALF, default 4, sys_clock cycles per SCL half-period (SCL = CLK_HZ/8).
REQ-003 Parameter BAUD_DIV, default 104, sys_clock cycles per UART bit (about 115200 baud at 12 MHz).
REQ-004 Parameter SAMPLE_DIV, default 120_000, sys_clock cycles between sample reads (100 Hz).
REQ-005 sys_clock  in  1  system clock; one clock domain; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset; the board wrapper drives it as ~KEY.
REQ-007 MOSI  out  1  SPI master data out to the accelerometer.
REQ-008 MISO  in  1  SPI data in from the accelerometer.
REQ-009 SCL  out  1  SPI clock.
REQ-010 CS  out  1  SPI chip select, active-low.
REQ-011 INT1, INT2  in  1 each  accelerometer interrupts; ignored.
REQ-012 UART_RX  in  1  ignored.
REQ-013 UART_TX  out  1  UART transmit line, 8N1, idle high.
REQ-014 LEDR  out  8  display of the latest X-axis low byte.

Function
REQ-015 SPI shall use mode 3:
- SCL idles high.
- MOSI changes on the SCL falling edge; MISO is sampled on the SCL rising edge.
- Bytes are sent MSB first.
REQ-016 CS shall fall one half-period before the first SCL falling edge and rise one half-period after the last rising edge.
REQ-017 CS shall stay high for at least 2 half-periods between transactions.
REQ-018 Controller states: INIT_WAIT, CFG_WRITE, IDLE, READ, UART_SEND.
REQ-019 INIT_WAIT shall last 16 sys_clock cycles after reset release, then go to CFG_WRITE.
REQ-020 CFG_WRITE shall run one 2-byte transaction, 0x2D then 0x08 (POWER_CTL = measure), then go to IDLE.
REQ-021 IDLE shall wait for the sample tick, then go to READ.
REQ-022 The sample tick is a free-running counter pulsing every SAMPLE_DIV cycles, counting from reset release.
REQ-023 READ shall run one 7-byte transaction:
- Byte 0 is command 0xF2 (read, multi-byte, address 0x32).
- Bytes 1-6 capture X0, X1, Y0, Y1, Z0, Z1 from MISO.
- MOSI shall be 0 while the data bytes are clocked.
REQ-024 On the CS rise ending READ:
- LEDR shall load X0.
- The frame 0xA5, X0, X1, Y0, Y1, Z0, Z1 shall be latched.
- The state shall go to UART_SEND.
REQ-025 UART_SEND shall transmit the 7-byte frame back-to-back, then return to IDLE.
- Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit BAUD_DIV cycles long.
REQ-026 A sample tick arriving during READ or UART_SEND shall be dropped, not queued.
REQ-027 Transaction length shall be driven by a bit counter only; the design shall not depend on INT1 or INT2.

Reset
REQ-028 While reset is high, outputs shall take these values immediately:
- CS=1, SCL=1, MOSI=0, UART_TX=1, LEDR=0x00.
- State INIT_WAIT; all counters and the frame buffer cleared.
REQ-029 Reset asserted mid-transaction or mid-UART shall abort that operation with no partial frame.
REQ-030 After reset release, the block shall restart from INIT_WAIT and repeat CFG_WRITE.

Verification
REQ-031 Reset held high for 300 ns, then released: CS, SCL and UART_TX stay high and LEDR=0 until CFG_WRITE starts, 16 cycles after release.
REQ-032 After release: the first CS-low window carries exactly 16 SCL rising edges, and MOSI sampled on them reads 0x2D, 0x08.
REQ-033 Slave returns 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on a READ:
- MOSI byte 0 is 0xF2.
- LEDR becomes 0x11 on the CS rise.
- UART_TX decodes to A5 11 22 33 44 55 66, each bit 104 cycles.
REQ-034 With SAMPLE_DIV set shorter than one READ plus UART frame, reads still never overlap and every UART frame is complete.
REQ-035 Reset asserted during READ byte 3:
- CS goes high asynchronously and LEDR is 0.
- No UART start bit follows; after release, CFG_WRITE repeats.
REQ-036 Toggling INT1, INT2 and UART_RX arbitrarily shall change neither SPI nor UART timing.
